mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_mem_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default geometry,
// state encoding and the debug view of the arbiter's internal state.
package cpu_mem_pkg;

  localparam int LAT_DEF = 4;
  localparam int AW_DEF  = 16;
  localparam int DW_DEF  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  // Consecutive contested data grants allowed before fetch is forced through.
  localparam logic [1:0] DSTREAK_MAX = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic [3:0] cnt;
    logic [1:0] dstreak;
  } arb_dbg_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory with a
// fixed access latency; data has priority, bounded by a starvation guard.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int LAT = LAT_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output arb_dbg_t      dbg
);

  // Handshake: a port raises req and holds it (with stable address/data) until
  // its valid pulse; req still high in the valid cycle is a fresh request.

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] dstreak;
  logic       wr_q;
  logic       d_wins;
  logic       last_cycle;

  assign d_wins     = d_req && !(if_req && (dstreak == DSTREAK_MAX));
  assign last_cycle = (cnt == 4'(LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      dstreak   <= 2'd0;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_wins) begin
            state     <= ST_BUSY_D;
            cnt       <= 4'd0;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wr_q      <= d_wr;
            if (!if_req)
              dstreak <= 2'd0;
            else if (dstreak != DSTREAK_MAX)
              dstreak <= dstreak + 2'd1;
          end else if (if_req) begin
            state    <= ST_BUSY_I;
            cnt      <= 4'd0;
            mem_addr <= if_addr;
            wr_q     <= 1'b0;
            dstreak  <= 2'd0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (last_cycle) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            if (state == ST_BUSY_I) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              // Stores complete with a pulse but leave the load result alone.
              if (!wr_q)
                d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign mem_en = (state == ST_BUSY_I) || (state == ST_BUSY_D);
  assign mem_wr = (state == ST_BUSY_D) && wr_q;
  assign stall  = (if_req && !if_valid) || (d_req && !d_valid);
  assign dbg    = {state, cnt, dstreak};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int EW  = DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_req = 0, d_req = 0, d_wr = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, d_valid, mem_en, mem_wr, stall;
  arb_dbg_t      dbg;

  logic          use_hash = 1'b1;
  logic [DW-1:0] mem_rd_drv = '0;

  logic          if_req_b = 0;
  logic [AW-1:0] if_addr_b = '0;
  logic [DW-1:0] if_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0] mem_addr_b;
  logic          if_valid_b, d_valid_b, mem_en_b, mem_wr_b, stall_b;
  arb_dbg_t      dbg_b;

  // Memory contents seen by the arbiter: a fixed scramble of the address.
  function automatic logic [DW-1:0] hashf(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  assign mem_rdata   = use_hash ? hashf(mem_addr) : mem_rd_drv;
  assign mem_rdata_b = hashf(mem_addr_b);

  mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .dbg(dbg)
  );

  mem_arbiter #(.LAT(1), .AW(AW), .DW(DW)) dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_rdata(d_rdata_b), .d_valid(d_valid_b),
    .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .stall(stall_b), .dbg(dbg_b)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem_val;
    logic [DW-1:0] exp_if;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  // Single isolated access; called right after an edge (#1) with the bus idle.
  task automatic run_single(input string tag, input vec_t v);
    int n, en_cnt, vat, sig_bad;
    logic got_d;
    use_hash   = 1'b0;
    mem_rd_drv = 16'hDEAD;
    if (v.is_d) begin
      d_req = 1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    n = 0; en_cnt = 0; vat = 0; sig_bad = 0; got_d = 0;
    while (vat == 0 && n < LAT + 6) begin
      @(posedge clk); #1;
      n++;
      if (mem_en) begin
        en_cnt++;
        if (mem_addr !== v.addr || mem_wr !== (v.is_d & v.wr) ||
            (v.is_d && mem_wdata !== v.wdata))
          sig_bad++;
      end
      // Inputs of the granted port are scrambled; the latched copy must be used.
      if (v.is_d) begin d_addr = ~v.addr; d_wdata = ~v.wdata; d_wr = ~v.wr; end
      else if_addr = ~v.addr;
      mem_rd_drv = (n == LAT) ? v.mem_val : 16'hDEAD;
      if (if_valid || d_valid) begin
        vat = n; got_d = d_valid;
        if_req = 0; d_req = 0;
      end
    end
    chk({tag, "_latency"}, 32'(vat), 32'(LAT + 1));
    chk({tag, "_mem_en_cycles"}, 32'(en_cnt), 32'(LAT));
    chk({tag, "_mem_signals_bad"}, 32'(sig_bad), 32'd0);
    chk({tag, "_valid_port"}, {31'd0, got_d}, {31'd0, v.is_d});
    chk({tag, "_if_rdata"}, {16'd0, if_rdata}, {16'd0, v.exp_if});
    chk({tag, "_d_rdata"}, {16'd0, d_rdata}, {16'd0, v.exp_d});
    @(posedge clk); #1;
    chk({tag, "_pulse_len"}, {30'd0, if_valid, d_valid}, 32'd0);
    chk({tag, "_idle_mem_en"}, {31'd0, mem_en}, 32'd0);
    use_hash = 1'b1;
  endtask

  logic [EW-1:0] exp_q[$];

  initial begin
    int d_at, i_at, stall_bad, ncomp, bad;
    logic [5:0] order;
    logic [EW-1:0] e;
    int k, next_arb, g_edge, streak;
    logic have_g, g_is_d, g_wr, busy, val, ifv_exp, dv_exp;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, exp_ifr, exp_dr;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA123, 16'hA123, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0042, 16'hBEEF, 16'h1111, 16'hA123, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h5555, 16'hA123, 16'h5555};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h5555};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h5555};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
    chk("rst_dbg", {24'd0, dbg}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 0;

    for (int i = 0; i < 6; i++) run_single($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: data first, then fetch
    if_req = 1; if_addr = 16'h0010; d_req = 1; d_wr = 0; d_addr = 16'h8000;
    d_at = 0; i_at = 0; stall_bad = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (d_valid) d_at = n;
      if (if_valid) i_at = n;
      if (stall !== (n < 10)) stall_bad++;
      if (d_valid) d_req = 0;
      if (if_valid) if_req = 0;
    end
    chk("simul_d_at", 32'(d_at), 32'd5);
    chk("simul_i_at", 32'(i_at), 32'd10);
    chk("simul_stall_bad", 32'(stall_bad), 32'd0);
    chk("simul_d_rdata", {16'd0, d_rdata}, {16'd0, hashf(16'h8000)});
    chk("simul_if_rdata", {16'd0, if_rdata}, {16'd0, hashf(16'h0010)});

    // Starvation guard with both ports held continuously
    if_req = 1; if_addr = 16'h0020; d_req = 1; d_wr = 0; d_addr = 16'h0030;
    ncomp = 0; order = '0;
    for (int n = 0; n < 60 && ncomp < 6; n++) begin
      @(posedge clk); #1;
      if (if_valid || d_valid) begin
        order = {order[4:0], d_valid};
        ncomp++;
        if (if_valid && ncomp == 3) chk("starve_dstreak_after_i", {30'd0, dbg.dstreak}, 32'd0);
        if (ncomp == 6) begin if_req = 0; d_req = 0; end
      end
    end
    chk("starve_count", 32'(ncomp), 32'd6);
    chk("starve_order", {26'd0, order}, 32'b110110);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of an access
    if_req = 1; if_addr = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_cnt_before", {28'd0, dbg.cnt}, 32'd2);
    rst = 1; if_req = 0;
    #1;
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("midrst_state", {30'd0, dbg.state}, {30'd0, ST_IDLE});
    @(posedge clk); #1;
    rst = 0;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (if_valid || d_valid || mem_en) bad++;
    end
    chk("midrst_no_valid", 32'(bad), 32'd0);
    run_single("postrst", '{1'b0, 1'b0, 16'h0300, 16'h0000, 16'h7E7E, 16'h7E7E, 16'h0000});

    // Randomized traffic against a transaction-level model
    rst = 1; #2; rst = 0;
    exp_ifr = '0; exp_dr = '0; exp_q.delete();
    k = 0; next_arb = 0; g_edge = 0; streak = 0; have_g = 0; g_is_d = 0;
    g_wr = 0; g_addr = '0; g_wdata = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // An access granted at edge g occupies edges g..g+LAT-1 and completes at g+LAT.
      if (k >= next_arb && (if_req || d_req)) begin
        g_is_d = d_req && !(if_req && streak == 2);
        if (g_is_d) begin
          g_addr = d_addr; g_wr = d_wr; g_wdata = d_wdata;
          streak = if_req ? ((streak < 2) ? streak + 1 : 2) : 0;
        end else begin
          g_addr = if_addr; g_wr = 0;
          streak = 0;
        end
        g_edge = k; have_g = 1; next_arb = k + LAT + 1;
        exp_q.push_back({g_is_d, g_wr, hashf(g_addr)});
      end
      @(posedge clk); #1;
      busy = have_g && k >= g_edge && k < g_edge + LAT;
      val = have_g && k == g_edge + LAT;
      ifv_exp = val && !g_is_d;
      dv_exp = val && g_is_d;
      chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, busy});
      if (busy) begin
        chk("rnd_mem_addr", {16'd0, mem_addr}, {16'd0, g_addr});
        chk("rnd_mem_wr", {31'd0, mem_wr}, {31'd0, g_is_d & g_wr});
        if (g_is_d) chk("rnd_mem_wdata", {16'd0, mem_wdata}, {16'd0, g_wdata});
      end
      chk("rnd_if_valid", {31'd0, if_valid}, {31'd0, ifv_exp});
      chk("rnd_d_valid", {31'd0, d_valid}, {31'd0, dv_exp});
      if (val && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e[DW+1]) exp_ifr = e[DW-1:0];
        else if (!e[DW]) exp_dr = e[DW-1:0];
      end
      chk("rnd_if_rdata", {16'd0, if_rdata}, {16'd0, exp_ifr});
      chk("rnd_d_rdata", {16'd0, d_rdata}, {16'd0, exp_dr});
      chk("rnd_stall", {31'd0, stall}, {31'd0, (if_req && !ifv_exp) || (d_req && !dv_exp)});
      if (ifv_exp) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 16'($urandom);
      end else if (busy && !g_is_d) begin
        if_addr = 16'($urandom);
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (dv_exp) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = 16'($urandom);
        d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end else if (busy && g_is_d) begin
        d_addr = 16'($urandom); d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = 16'($urandom);
        d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end
      k++;
    end
    if_req = 0; d_req = 0;
    repeat (LAT + 3) @(posedge clk);
    #1;

    // LAT=1 instance: back-to-back fetches complete every second cycle
    if_req_b = 1; if_addr_b = 16'h0123;
    bad = 0; ncomp = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if_valid_b !== (n % 2 == 0)) bad++;
      if (if_valid_b) begin
        ncomp++;
        if (if_rdata_b !== hashf(16'h0123)) bad++;
      end
    end
    if_req_b = 0;
    chk("lat1_pattern_bad", 32'(bad), 32'd0);
    chk("lat1_count", 32'(ncomp), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
